fetch_ctrl: RTL

//  Sequencer for the IF stage: owns the PC, issues word fetches to instruction memory with a req/ack handshake,
//  and presents fetched instructions to ID through a valid/ready interface. Applies branch/jump redirects
//  (PCSrc/Branch from EX) with flush, and absorbs ID back-pressure in a one-entry skid buffer.

---
 rtl/fetch_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer. It owns the PC, fetches words over imem req/ack, and delivers them to ID
// over valid/ready with a one-entry skid buffer. Optional macro FETCH_PERF_EN adds fetch_cnt/kill_cnt.
module fetch_ctrl #(
  parameter int unsigned     AW       = 32,
  parameter logic [AW-1:0]   RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          if_valid,
  input  logic          id_ready,
  output logic [31:0]   if_instr,
  output logic [AW-1:0] if_pc,
`ifdef FETCH_PERF_EN
  output logic [AW-1:0] if_next_pc,
  output logic [31:0]   fetch_cnt,
  output logic [31:0]   kill_cnt
`else
  output logic [AW-1:0] if_next_pc
`endif
);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2,
    S_KILL = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_nxt;
  logic [AW-1:0] r_kill_pc;
  logic [AW-1:0] w_kill_pc_nxt;
  logic          r_req;

  logic          r_out_valid;
  logic          w_out_valid_nxt;
  logic [31:0]   r_out_instr;
  logic [31:0]   w_out_instr_nxt;
  logic [AW-1:0] r_out_pc;
  logic [AW-1:0] w_out_pc_nxt;
  logic [AW-1:0] r_out_npc;
  logic [AW-1:0] w_out_npc_nxt;

  logic          r_skid_valid;
  logic          w_skid_valid_nxt;
  logic [31:0]   r_skid_instr;
  logic [31:0]   w_skid_instr_nxt;
  logic [AW-1:0] r_skid_pc;
  logic [AW-1:0] w_skid_pc_nxt;

  logic          w_xfer;
  logic          w_drop;
  logic [AW-1:0] w_redir_pc;
  logic          w_unused;

  function automatic logic [AW-1:0] inc_word(input logic [AW-1:0] a);
    return a + AW'(32'd4);
  endfunction

  assign w_xfer     = r_out_valid & id_ready;
  assign w_redir_pc = {redirect_pc[AW-1:2], 2'b00};

  // Next-state, PC and buffer steering; a redirect flushes both buffer entries
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_kill_pc_nxt    = r_kill_pc;
    w_out_valid_nxt  = r_out_valid & ~w_xfer & ~redirect;
    w_out_instr_nxt  = r_out_instr;
    w_out_pc_nxt     = r_out_pc;
    w_out_npc_nxt    = r_out_npc;
    w_skid_valid_nxt = r_skid_valid & ~redirect;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc_nxt    = r_skid_pc;
    w_drop           = 1'b0;

    case (r_state)
      S_RST: begin
        w_state_nxt = S_REQ;
        if (redirect) begin
          w_pc_nxt = w_redir_pc;
        end else begin
          w_pc_nxt = r_pc;
        end
      end

      S_REQ: begin
        if (redirect) begin
          if (imem_ack) begin
            w_pc_nxt = w_redir_pc;
            w_drop   = 1'b1;
          end else begin
            // Request already on the bus: keep the address until it is acked, then jump
            w_kill_pc_nxt = w_redir_pc;
            w_state_nxt   = S_KILL;
          end
        end else if (imem_ack) begin
          w_pc_nxt = inc_word(r_pc);
          if (!r_out_valid || id_ready) begin
            w_out_valid_nxt = 1'b1;
            w_out_instr_nxt = imem_rdata;
            w_out_pc_nxt    = r_pc;
            w_out_npc_nxt   = inc_word(r_pc);
          end else begin
            w_skid_valid_nxt = 1'b1;
            w_skid_instr_nxt = imem_rdata;
            w_skid_pc_nxt    = r_pc;
            w_state_nxt      = S_FULL;
          end
        end else begin
          w_state_nxt = S_REQ;
        end
      end

      S_FULL: begin
        if (redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_REQ;
        end else if (id_ready) begin
          w_out_valid_nxt  = 1'b1;
          w_out_instr_nxt  = r_skid_instr;
          w_out_pc_nxt     = r_skid_pc;
          w_out_npc_nxt    = inc_word(r_skid_pc);
          w_skid_valid_nxt = 1'b0;
          w_state_nxt      = S_REQ;
        end else begin
          w_state_nxt = S_FULL;
        end
      end

      S_KILL: begin
        if (imem_ack) begin
          w_drop      = 1'b1;
          w_state_nxt = S_REQ;
          if (redirect) begin
            w_pc_nxt = w_redir_pc;
          end else begin
            w_pc_nxt = r_kill_pc;
          end
        end else if (redirect) begin
          w_kill_pc_nxt = w_redir_pc;
        end else begin
          w_state_nxt = S_KILL;
        end
      end

      default: begin
        w_state_nxt = S_RST;
      end
    endcase
  end

  // State, PC and delivery registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_RST;
      r_pc         <= RESET_PC;
      r_kill_pc    <= RESET_PC;
      r_req        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_instr  <= 32'h0000_0000;
      r_out_pc     <= '0;
      r_out_npc    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= 32'h0000_0000;
      r_skid_pc    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_kill_pc    <= w_kill_pc_nxt;
      r_req        <= (w_state_nxt == S_REQ) || (w_state_nxt == S_KILL);
      r_out_valid  <= w_out_valid_nxt;
      r_out_instr  <= w_out_instr_nxt;
      r_out_pc     <= w_out_pc_nxt;
      r_out_npc    <= w_out_npc_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_pc;
  assign if_valid   = r_out_valid;
  assign if_instr   = r_out_instr;
  assign if_pc      = r_out_pc;
  assign if_next_pc = r_out_npc;

`ifdef FETCH_PERF_EN
  logic        r_kill_evt_unused_guard;
  logic        w_kill_evt;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_kill_cnt;

  // A word is lost when an ack is discarded or a buffered, untransferred word is flushed
  assign w_kill_evt = w_drop | (redirect & ((r_out_valid & ~id_ready) | r_skid_valid));

  // Performance counters, one increment per cycle at most
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt             <= 32'h0000_0000;
      r_kill_cnt              <= 32'h0000_0000;
      r_kill_evt_unused_guard <= 1'b0;
    end else begin
      r_fetch_cnt             <= r_fetch_cnt + {31'd0, w_xfer};
      r_kill_cnt              <= r_kill_cnt + {31'd0, w_kill_evt};
      r_kill_evt_unused_guard <= 1'b0;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign kill_cnt  = r_kill_cnt;
  assign w_unused  = ^{redirect_pc[1:0], r_kill_evt_unused_guard};
`else
  assign w_unused  = ^{redirect_pc[1:0], w_drop};
`endif

endmodule
